fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter sharing the write port of one fifo_async among NUM_REQ producers in the wr_clk domain.
//  Grants one requester at a time for a burst of up to MAX_BURST words, forwards its data to the FIFO
//  write port, and stalls while the FIFO reports full. Sits directly in front of the FIFO write side.
// PARAMETERS
//  NUM_REQ    4   number of requesters (2..8)
//  DATA_WIDTH 16  word width; matches FIFO data_width
//  MAX_BURST  8   max words per grant (1..256)
//  ID_WIDTH   2   width of owner id; must be >= clog2(NUM_REQ)
// PORTS
//  clk        in   1                    write-domain clock (FIFO wr_clk)
//  rst_n      in   1                    asynchronous reset, active low
//  req        in   NUM_REQ              per-requester valid; held until granted word transfers
//  req_data   in   NUM_REQ*DATA_WIDTH   packed data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//  gnt        out  NUM_REQ              one-hot ready; word transfers when req[i] & gnt[i]
//  fifo_full  in   1                    FIFO full flag
//  fifo_wr_en out  1                    FIFO write enable
//  fifo_din   out  DATA_WIDTH           FIFO write data
//  owner      out  ID_WIDTH             index of current grant owner (valid while busy)
//  busy       out  1                    high in GRANT state
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, gnt=0, fifo_wr_en=0, fifo_din=0, owner=0, busy=0,
//    burst_cnt=0, last_winner=NUM_REQ-1 (so req[0] has top priority after reset).
//  - States: IDLE, GRANT. Registered: state, owner, burst_cnt, last_winner.
//  - IDLE: if |req, pick first set req searching last_winner+1, +2, ... (mod NUM_REQ);
//    next cycle state=GRANT, owner=winner, last_winner=winner, burst_cnt=0. fifo_full ignored here.
//  - GRANT: gnt[owner] = ~fifo_full (combinational), all other gnt bits 0.
//    fifo_wr_en = req[owner] & ~fifo_full; fifo_din = req_data slice of owner, else 0.
//    Each transfer increments burst_cnt (width clog2(MAX_BURST)+1, no wrap).
//  - GRANT exit to IDLE (next edge) when: transfer with burst_cnt==MAX_BURST-1, or req[owner]==0.
//    Stall on full does NOT count toward burst and does not release the grant.
//  - Latency: req rise in IDLE -> gnt at next cycle; one-cycle IDLE bubble between grants.
//  - Fairness: requester holding req continuously is granted within NUM_REQ grant periods.
//  - fifo_full rising mid-burst: gnt/fifo_wr_en drop same cycle; resume same owner when full clears.
//  - Requester dropping req mid-burst: no write that cycle, grant released, round-robin continues.
//  - Single requester always active: re-granted after each burst with one bubble cycle.
//  - rst_n asserted mid-burst: outputs go to reset values immediately; no partial word written.
//  - Never more than one gnt bit set; fifo_wr_en never high while fifo_full high.
// CONFIGURATION
//  FIFO_WR_ARB_STATS_EN defined: adds ports stats_clr (in, 1) and word_cnt (out, NUM_REQ*32);
//    word_cnt[i] increments on every transfer from requester i, saturates at 32'hFFFF_FFFF,
//    synchronous clear by stats_clr (clear wins over increment), reset to 0 by rst_n.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  T1 reset: rst_n=0 with req=4'b1111 -> gnt=0, fifo_wr_en=0, busy=0; release -> first owner=0.
//  T2 rotation: req=4'b1111 steady, fifo_full=0, MAX_BURST=8 -> owners 0,1,2,3,0; 8 writes each,
//     1 bubble cycle between bursts.
//  T3 backpressure: owner 2 mid-burst after 3 words, fifo_full=1 for 5 cycles -> gnt=0, wr_en=0,
//     then 5 more words from requester 2, burst ends at 8.
//  T4 early release: req[1] drops after 2 words -> next edge IDLE, next grant to requester 2 if requesting.
//  T5 async reset mid-burst: rst_n pulsed low during write -> wr_en falls without clock edge,
//     last_winner back to NUM_REQ-1.
//  T6 STATS_EN: 20 words from req0, 5 from req3 -> word_cnt0=20, cnt3=5; stats_clr -> all 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers, granting bursts of up to MAX_BURST words.
// Optional per-requester word counters are built when FIFO_WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [ID_WIDTH-1:0]           owner,
    output logic                          busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic                          stats_clr,
    output logic [NUM_REQ*32-1:0]         word_cnt
`endif
);

    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    // Handshake: req[i] is valid, gnt[i] is ready; a word moves on a clock edge
    // where both are high. gnt does not wait for req, so producers must not depend on it.
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t              state, state_nx;
    logic [ID_WIDTH-1:0] owner_q;
    logic [ID_WIDTH-1:0] last_winner;
    logic [ID_WIDTH-1:0] winner;
    logic [CNT_W-1:0]    burst_cnt;
    logic                any_req;
    logic                owner_req;
    logic                xfer;
    logic                burst_last;
    logic                found;
    int                  idx;
    int                  owner_i;

    assign any_req    = |req;
    assign owner_i    = int'(owner_q);
    assign owner_req  = req[owner_i];
    assign xfer       = (state == GRANT) && owner_req && !fifo_full;
    assign burst_last = (burst_cnt == CNT_W'(MAX_BURST - 1));
    assign owner      = owner_q;

    // Search starts one past the previous winner so every requester eventually gets a turn.
    always_comb begin
        winner = last_winner;
        found  = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_winner) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                winner = ID_WIDTH'(idx);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner_q     <= '0;
            last_winner <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt   <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner_q     <= winner;
                last_winner <= winner;
                burst_cnt   <= '0;
            end else if (xfer) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    // A full stall neither counts toward the burst nor releases the grant.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = GRANT;
            GRANT:   if (!owner_req || (xfer && burst_last)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        fifo_wr_en = 1'b0;
        fifo_din   = '0;
        busy       = (state == GRANT);
        if (state == GRANT) begin
            gnt[owner_i] = !fifo_full;
            fifo_wr_en   = xfer;
            if (xfer) fifo_din = req_data[owner_i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stats
        logic [31:0] cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
            end else if (stats_clr) begin
                cnt <= '0;
            end else if (xfer && owner_i == i && cnt != 32'hFFFF_FFFF) begin
                cnt <= cnt + 32'd1;
            end
        end
        assign word_cnt[i*32 +: 32] = cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed corner sequences and
// randomized traffic against a transaction-level round-robin model.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int MAX_BURST  = 8;
    localparam int ID_WIDTH   = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] req_data = '0;
    logic [3:0]  gnt;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [15:0] fifo_din;
    logic [1:0]  owner;
    logic        busy;
`ifdef FIFO_WR_ARB_STATS_EN
    logic         stats_clr = 1'b0;
    logic [127:0] word_cnt;
`endif

    int checks = 0;
    int errors = 0;

    fifo_wr_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST), .ID_WIDTH(ID_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din),
        .owner(owner), .busy(busy)
`ifdef FIFO_WR_ARB_STATS_EN
        , .stats_clr(stats_clr), .word_cnt(word_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: grant period bookkeeping in plain integers.
    bit m_busy;
    int m_owner;
    int m_last;
    int m_words;

    function automatic int rr_pick(int last, logic [3:0] r);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return last;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_last  <= NUM_REQ - 1;
            m_words <= 0;
        end else if (!m_busy) begin
            if (|req) begin
                m_busy  <= 1'b1;
                m_owner <= rr_pick(m_last, req);
                m_last  <= rr_pick(m_last, req);
                m_words <= 0;
            end
        end else begin
            if (req[m_owner] && !fifo_full) m_words <= m_words + 1;
            if (!req[m_owner] || (!fifo_full && m_words + 1 == MAX_BURST)) m_busy <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, then let outputs settle.
    task automatic cyc(input logic [3:0] r, input logic f, input logic [63:0] d);
        @(negedge clk);
        req       = r;
        fifo_full = f;
        req_data  = d;
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req       = '0;
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_model(input string nm);
        logic [3:0]  e_gnt;
        logic        e_wr;
        logic [15:0] e_din;
        e_gnt = (m_busy && !fifo_full) ? (4'b0001 << m_owner) : 4'b0000;
        e_wr  = m_busy && req[m_owner] && !fifo_full;
        e_din = e_wr ? req_data[m_owner*16 +: 16] : 16'h0;
        chk({nm, "_busy"}, 32'(busy), 32'(m_busy));
        chk({nm, "_gnt"}, 32'(gnt), 32'(e_gnt));
        chk({nm, "_wr_en"}, 32'(fifo_wr_en), 32'(e_wr));
        chk({nm, "_din"}, 32'(fifo_din), 32'(e_din));
        if (m_busy) chk({nm, "_owner"}, 32'(owner), 32'(m_owner));
    endtask

    typedef struct {
        logic [3:0]  r;
        logic        f;
        logic [3:0]  gnt;
        logic        wr;
        logic        busy;
        logic [1:0]  own;
        logic [15:0] din;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [3:0]  rr;
        logic [63:0] d;
        int          n;
        int          guard;

        vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[1]  = '{4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0, 16'hD000};
        vecs[2]  = '{4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[4]  = '{4'b1010, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[5]  = '{4'b1010, 1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 16'hD001};
        vecs[6]  = '{4'b1000, 1'b0, 4'b0010, 1'b0, 1'b1, 2'd1, 16'h0000};
        vecs[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[8]  = '{4'b1001, 1'b0, 4'b1000, 1'b1, 1'b1, 2'd3, 16'hD003};
        vecs[9]  = '{4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3, 16'h0000};
        vecs[10] = '{4'b1001, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000};
        vecs[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 16'h0000};
        vecs[12] = '{4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0, 16'h0000};

        // T1: reset with every requester active
        rst_n = 1'b0;
        req   = 4'b1111;
        req_data = rnd64();
        #12;
        chk("t1_rst_gnt", 32'(gnt), 32'h0);
        chk("t1_rst_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("t1_rst_busy", 32'(busy), 32'h0);
        chk("t1_rst_din", 32'(fifo_din), 32'h0);
        chk("t1_rst_owner", 32'(owner), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t1_idle_busy", 32'(busy), 32'h0);
        cyc(4'b1111, 1'b0, rnd64());
        chk("t1_first_busy", 32'(busy), 32'h1);
        chk("t1_first_owner", 32'(owner), 32'h0);
        chk("t1_first_gnt", 32'(gnt), 32'h1);

        // Vector table
        do_reset();
        for (int i = 0; i < 13; i++) begin
            cyc(vecs[i].r, vecs[i].f, 64'hD003_D002_D001_D000);
            chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_wr_en", i), 32'(fifo_wr_en), 32'(vecs[i].wr));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
            chk($sformatf("vec%0d_din", i), 32'(fifo_din), 32'(vecs[i].din));
            if (vecs[i].busy) chk($sformatf("vec%0d_owner", i), 32'(owner), 32'(vecs[i].own));
        end

        // T2: steady rotation with full bursts and one bubble between grants
        do_reset();
        for (int b = 0; b < 5; b++) begin
            cyc(4'b1111, 1'b0, rnd64());
            chk($sformatf("t2_bubble%0d", b), 32'(busy), 32'h0);
            for (int w = 0; w < MAX_BURST; w++) begin
                d = rnd64();
                cyc(4'b1111, 1'b0, d);
                chk($sformatf("t2_b%0d_w%0d_owner", b, w), 32'(owner), 32'(b % 4));
                chk($sformatf("t2_b%0d_w%0d_wr_en", b, w), 32'(fifo_wr_en), 32'h1);
                chk($sformatf("t2_b%0d_w%0d_gnt", b, w), 32'(gnt), 32'(4'b0001 << (b % 4)));
                chk($sformatf("t2_b%0d_w%0d_din", b, w), 32'(fifo_din), 32'(d[(b % 4)*16 +: 16]));
            end
        end

        // T3: backpressure mid-burst keeps the grant and does not count
        do_reset();
        cyc(4'b0100, 1'b0, rnd64());
        chk("t3_bubble", 32'(busy), 32'h0);
        for (int w = 0; w < 3; w++) begin
            cyc(4'b0100, 1'b0, rnd64());
            chk("t3_pre_wr_en", 32'(fifo_wr_en), 32'h1);
            chk("t3_pre_owner", 32'(owner), 32'h2);
        end
        for (int s = 0; s < 5; s++) begin
            cyc(4'b0100, 1'b1, rnd64());
            chk("t3_stall_gnt", 32'(gnt), 32'h0);
            chk("t3_stall_wr_en", 32'(fifo_wr_en), 32'h0);
            chk("t3_stall_busy", 32'(busy), 32'h1);
            chk("t3_stall_owner", 32'(owner), 32'h2);
        end
        for (int w = 0; w < 5; w++) begin
            d = rnd64();
            cyc(4'b0100, 1'b0, d);
            chk("t3_post_wr_en", 32'(fifo_wr_en), 32'h1);
            chk("t3_post_din", 32'(fifo_din), 32'(d[47:32]));
        end
        cyc(4'b0100, 1'b0, rnd64());
        chk("t3_burst_end", 32'(busy), 32'h0);

        // T4: requester drops mid-burst, rotation moves on
        do_reset();
        cyc(4'b0110, 1'b0, rnd64());
        chk("t4_bubble", 32'(busy), 32'h0);
        for (int w = 0; w < 2; w++) begin
            cyc(4'b0110, 1'b0, rnd64());
            chk("t4_owner1", 32'(owner), 32'h1);
            chk("t4_wr_en", 32'(fifo_wr_en), 32'h1);
        end
        cyc(4'b0100, 1'b0, rnd64());
        chk("t4_drop_wr_en", 32'(fifo_wr_en), 32'h0);
        cyc(4'b0100, 1'b0, rnd64());
        chk("t4_released", 32'(busy), 32'h0);
        cyc(4'b0100, 1'b0, rnd64());
        chk("t4_next_owner", 32'(owner), 32'h2);
        chk("t4_next_busy", 32'(busy), 32'h1);

        // T5: asynchronous reset in the middle of a write
        do_reset();
        cyc(4'b0010, 1'b0, rnd64());
        cyc(4'b0010, 1'b0, rnd64());
        chk("t5_pre_wr_en", 32'(fifo_wr_en), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_wr_en", 32'(fifo_wr_en), 32'h0);
        chk("t5_async_gnt", 32'(gnt), 32'h0);
        chk("t5_async_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1110;
        #1;
        chk("t5_idle", 32'(busy), 32'h0);
        cyc(4'b1110, 1'b0, rnd64());
        chk("t5_owner_after_rst", 32'(owner), 32'h1);

`ifdef FIFO_WR_ARB_STATS_EN
        // T6: per-requester word counters and clear
        do_reset();
        n = 0;
        guard = 0;
        while (n < 20 && guard < 200) begin
            cyc(4'b0001, 1'b0, rnd64());
            if (fifo_wr_en) n++;
            guard++;
        end
        chk("t6_req0_timeout", 32'(guard < 200), 32'h1);
        n = 0;
        guard = 0;
        while (n < 5 && guard < 200) begin
            cyc(4'b1000, 1'b0, rnd64());
            if (fifo_wr_en) n++;
            guard++;
        end
        chk("t6_req3_timeout", 32'(guard < 200), 32'h1);
        cyc(4'b0000, 1'b0, rnd64());
        chk("t6_cnt0", word_cnt[31:0], 32'd20);
        chk("t6_cnt1", word_cnt[63:32], 32'd0);
        chk("t6_cnt2", word_cnt[95:64], 32'd0);
        chk("t6_cnt3", word_cnt[127:96], 32'd5);
        @(negedge clk);
        stats_clr = 1'b1;
        @(negedge clk);
        stats_clr = 1'b0;
        #1;
        chk("t6_clr0", word_cnt[31:0], 32'd0);
        chk("t6_clr3", word_cnt[127:96], 32'd0);
`endif

        // Randomized traffic against the model
        do_reset();
        rr = 4'b0000;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) rr[b] = ~rr[b];
            end
            cyc(rr, ($urandom_range(0, 4) == 0), rnd64());
            check_model("rnd");
            chk("rnd_onehot", 32'($countones(gnt) <= 1), 32'h1);
            chk("rnd_no_wr_full", 32'(fifo_wr_en && fifo_full), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
